burst_accumulator: RTL and testbench
====================================

BURST_ACCUMULATOR -- requirements
Module: burst_accumulator

Interface
REQ-001 SHALL have parameter N, default 32: operand and sum width in bits.
REQ-002 SHALL have parameter CNT_W, default 8: word-count width in bits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream word present.
REQ-006 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-007 SHALL have port in_data  input  N  operand word.
REQ-008 SHALL have port in_last  input  1  the word is the final word of its burst.
REQ-009 SHALL have port out_valid  output  1  burst result present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have port out_sum  output  N  burst sum modulo 2^N.
REQ-012 SHALL have port out_ovf  output  1  sticky carry-out seen during the burst.
REQ-013 SHALL have port out_count  output  CNT_W  number of words in the burst, saturating.

Function
REQ-014 SHALL implement FSM states IDLE, ACC and HOLD, with IDLE after reset.
REQ-015 SHALL define an accept as in_valid & in_ready at a rising clk edge.
REQ-016 SHALL drive in_ready = 1 in IDLE and ACC and 0 in HOLD, combinationally from state only.
REQ-017 SHALL, on an accept in IDLE, load acc = in_data, ovf = 0 and count = 1.
REQ-018 SHALL, on an accept in ACC, update acc = acc + in_data (carry-in 0), ovf = ovf | carry-out and count = count + 1, with count saturating at 2^CNT_W-1.
REQ-019 SHALL, on an accept with in_last = 0, go to (or remain in) ACC.
REQ-020 SHALL, on an accept with in_last = 1, go to HOLD so that the final word is included in the result.
REQ-021 SHALL assert out_valid in the cycle after the in_last accept, giving a latency of 1 cycle.
REQ-022 SHALL, with no accept in IDLE or ACC (in_valid = 0), hold all state.
REQ-023 SHALL, in HOLD, keep out_valid = 1 and keep out_sum, out_ovf and out_count stable until out_valid & out_ready.
REQ-024 SHALL, on out_valid & out_ready, go to IDLE with out_valid = 0 on the next cycle, and SHALL NOT accept an input word in that same cycle.
REQ-025 SHALL drive out_sum, out_ovf and out_count directly from the acc, ovf and count registers; they retain their values in IDLE and are meaningful only while out_valid = 1.
REQ-026 SHALL treat a single-word burst (in_last on the first word) as out_sum = in_data, out_count = 1 and out_ovf = 0.
REQ-027 SHALL ignore in_data and in_last whenever in_valid = 0.

Reset
REQ-028 SHALL, when reset = 1 at a clk edge, set state = IDLE, acc = 0, ovf = 0, count = 0 and out_valid = 0, so that out_sum = 0, out_ovf = 0 and out_count = 0 while in_ready = 1.
REQ-029 SHALL, on reset mid-burst or during HOLD, discard the partial or pending result with no output handshake.
REQ-030 SHALL give reset priority over every simultaneous accept or output handshake.

Structure
REQ-031 SHALL place the FSM state encoding (2 bits) and the default N and CNT_W values in the shared package.
REQ-032 SHALL perform the addition in one combinational sub-module, ripple_adder (N-bit, carry-in and carry-out), instantiated once with carry-in tied to 0.
REQ-033 SHALL keep the FSM, acc, ovf and count registers in burst_accumulator.

Verification
REQ-034 SHALL cover, with N=8: 0x10, 0x20, 0x30(last) -> out_sum 0x60, out_ovf 0, out_count 3, out_valid high the cycle after the last accept.
REQ-035 SHALL cover, with N=8: 0xFF, 0x02(last) -> out_sum 0x01, out_ovf 1, out_count 2; next burst 0x05(last) -> out_sum 0x05, out_ovf 0, out_count 1.
REQ-036 SHALL cover backpressure: out_ready = 0 for 5 cycles in HOLD -> in_ready 0 and outputs unchanged; out_ready = 1 -> out_valid 0 and in_ready 1 on the next cycle.
REQ-037 SHALL cover reset mid-burst: after 0x10 and 0x20, reset for 1 cycle -> out_sum 0, out_count 0, out_valid 0; then 0x07(last) -> out_sum 0x07, out_count 1.
REQ-038 SHALL cover in_valid bubbles: 0x01, gap of 3 cycles, 0x02, gap of 1 cycle, 0x03(last) -> out_sum 0x06, out_count 3.
REQ-039 SHALL cover saturation with CNT_W=2: five words of 0x01 (last on the fifth) -> out_count 3, out_sum 0x05, out_ovf 0.

Source files
------------

// File: rtl/burst_accumulator_pkg.sv
// Shared definitions for the burst accumulator: FSM encoding and default widths.
package burst_accumulator_pkg;

    localparam int DEFAULT_N     = 32;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/burst_accumulator_ripple_adder.sv
// Combinational N-bit ripple-carry adder with carry-in and carry-out.
module ripple_adder #(
    parameter int N = burst_accumulator_pkg::DEFAULT_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    always_comb begin
        logic carry;
        carry = cin;
        sum   = '0;
        for (int i = 0; i < N; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/burst_accumulator.sv
// Sums a valid/ready burst of words terminated by in_last and presents the sum,
// a sticky carry flag and a saturating word count until downstream takes it.
module burst_accumulator #(
    parameter int N     = burst_accumulator_pkg::DEFAULT_N,
    parameter int CNT_W = burst_accumulator_pkg::DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    import burst_accumulator_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [N-1:0]     acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [N-1:0]     add_sum;
    logic             add_cout;
    logic             accept;

    ripple_adder #(.N(N)) u_adder (
        .a    (acc_q),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign in_ready  = (state_q != HOLD);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid & in_ready;

    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_count = count_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    // The first word of a burst replaces whatever result is still parked in the registers
                    if (state_q == IDLE) begin
                        acc_d   = in_data;
                        ovf_d   = 1'b0;
                        count_d = CNT_ONE;
                    end else begin
                        acc_d   = add_sum;
                        ovf_d   = ovf_q | add_cout;
                        count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
                    end
                    state_d = in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_burst_accumulator.sv
// Directed bench: stimulus pushes hand-computed burst results, a monitor checks each handshake.
module tb_burst_accumulator;

    localparam int N     = 8;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_sum;
    logic             out_ovf;
    logic [CNT_W-1:0] out_count;

    typedef struct {
        logic [N-1:0]     sum;
        logic             ovf;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    burst_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [N-1:0] s, input logic o, input logic [CNT_W-1:0] c);
        exp_t e;
        e.sum = s;
        e.ovf = o;
        e.cnt = c;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [N-1:0] d, input logic l);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!in_ready) begin
            total_cnt++;
            $display("FAIL send_timeout: in_ready stuck at 0 for word 0x%0h", d);
        end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_result: sum 0x%0h with empty scoreboard", out_sum);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("out_sum", 32'(out_sum), 32'(e.sum));
                chk("out_ovf", 32'(out_ovf), 32'(e.ovf));
                chk("out_count", 32'(out_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        chk("rst_out_sum", 32'(out_sum), 32'h0);
        chk("rst_out_ovf", 32'(out_ovf), 32'h0);
        chk("rst_out_count", 32'(out_count), 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);

        // three-word burst, result visible the cycle after the last accept
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        push(8'h60, 1'b0, 2'd3);
        send(8'h30, 1'b1);
        @(negedge clk);
        chk("latency_out_valid", 32'(out_valid), 32'h1);

        // carry-out sets the sticky flag; the next burst clears it
        send(8'hFF, 1'b0);
        push(8'h01, 1'b1, 2'd2);
        send(8'h02, 1'b1);
        push(8'h05, 1'b0, 2'd1);
        send(8'h05, 1'b1);

        // backpressure: result held for five cycles, stray inputs refused
        tick();
        out_ready = 1'b0;
        send(8'h11, 1'b0);
        push(8'h33, 1'b0, 2'd2);
        send(8'h22, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'h1);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
            chk("bp_out_sum", 32'(out_sum), 32'h33);
            chk("bp_out_count", 32'(out_count), 32'h2);
            in_valid = 1'b1;
            in_data  = 8'hAA;
            in_last  = 1'b1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_out_valid", 32'(out_valid), 32'h0);
        chk("release_in_ready", 32'(in_ready), 32'h1);

        // reset in the middle of a burst discards it
        tick();
        send(8'h10, 1'b0);
        send(8'h20, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_sum", 32'(out_sum), 32'h0);
        chk("midrst_out_count", 32'(out_count), 32'h0);
        chk("midrst_out_valid", 32'(out_valid), 32'h0);
        push(8'h07, 1'b0, 2'd1);
        send(8'h07, 1'b1);

        // idle gaps between words
        send(8'h01, 1'b0);
        repeat (3) tick();
        send(8'h02, 1'b0);
        tick();
        push(8'h06, 1'b0, 2'd3);
        send(8'h03, 1'b1);

        // count saturates at 3 with a 2-bit counter
        for (int i = 0; i < 4; i++) send(8'h01, 1'b0);
        push(8'h05, 1'b0, 2'd3);
        send(8'h01, 1'b1);

        repeat (4) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
